cxu_mac: RTL and testbench

Multiply-accumulate composable extension unit (CXU) sitting directly downstream of the CX switch, on one port of its CXU-side interface. It accepts a request (function, state context, two 32-bit operands) under the switch's valid/ready handshake and executes it. The state context is one of N_STATES per-context 32-bit accumulators. It returns a 32-bit result plus status through a one-cycle ready pulse. Multiplies are iterative (radix-2 shift-add) to keep area small.

---
 rtl/cxu_mac_pkg.sv | 32 +++
 rtl/cxu_mul_iter.sv | 51 +++++
 rtl/cxu_mac.sv | 123 ++++++++++++
 tb/tb_cxu_mac.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cxu_mac_pkg.sv
// Shared types and constants for the multiply-accumulate CXU.
package cxu_mac_pkg;

  // Shift-add multiplier: one partial product per cycle.
  localparam int MUL_ITERS = 32;
  localparam int CNT_W     = $clog2(MUL_ITERS);

  typedef enum logic [2:0] {
    FUNC_ADD    = 3'd0,
    FUNC_MUL    = 3'd1,
    FUNC_MAC    = 3'd2,
    FUNC_RDACC  = 3'd3,
    FUNC_WRACC  = 3'd4,
    FUNC_CLRACC = 3'd5
  } func_e;

  localparam logic [3:0] STATUS_OK        = 4'd0;
  localparam logic [3:0] STATUS_ILL_FUNC  = 4'd1;
  localparam logic [3:0] STATUS_ILL_STATE = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  // Functions that address an accumulator context and so need a legal state_id.
  function automatic logic func_uses_state(input logic [2:0] func);
    return (func >= 3'(FUNC_MAC)) && (func <= 3'(FUNC_CLRACC));
  endfunction

endpackage

// File: rtl/cxu_mul_iter.sv
// Radix-2 shift-add multiplier producing the low 32 bits of a*b.
// 'done' is high during the last iteration cycle, with 'product' already
// holding the final value so the caller can consume it on that same edge.
module cxu_mul_iter
  import cxu_mac_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] product
);

  logic [31:0]      mcand;
  logic [31:0]      mplier;
  logic [31:0]      prod;
  logic [CNT_W-1:0] cnt;
  logic             active;
  logic [31:0]      prod_step;

  // Partial sum including the current iteration's add.
  assign prod_step = prod + (mplier[0] ? mcand : 32'd0);
  assign done      = active && (cnt == CNT_W'(MUL_ITERS - 1));
  assign product   = prod_step;

  // Load operands on start, then shift and accumulate one bit per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      prod   <= '0;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      prod   <= prod_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/cxu_mac.sv
// Multiply-accumulate CXU: ADD/MUL/MAC plus accumulator read/write/clear
// over N_STATES contexts, answering each request with a one-cycle pulse.
module cxu_mac
  import cxu_mac_pkg::*;
#(
  parameter int N_STATES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_func,
  input  logic [1:0]  req_state_id,
  input  logic [31:0] req_data0,
  input  logic [31:0] req_data1,
  output logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [3:0]  resp_status,
  output logic        busy
);

  fsm_e        state;
  logic [2:0]  func_q;
  logic [1:0]  sid_q;
  logic [31:0] acc [N_STATES];

  logic        legal_func;
  logic        legal_state;
  logic        mul_start;
  logic        mul_done;
  logic [31:0] mul_product;
  logic [31:0] mac_sum;

  assign legal_func  = (req_func <= 3'(FUNC_CLRACC));
  assign legal_state = (int'(req_state_id) < N_STATES);
  assign mul_start   = (state == ST_IDLE) && req_valid && legal_func &&
                       ((req_func == 3'(FUNC_MUL)) ||
                        ((req_func == 3'(FUNC_MAC)) && legal_state));
  assign mac_sum     = acc[sid_q] + mul_product;

  cxu_mul_iter u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (req_data0),
    .b       (req_data1),
    .done    (mul_done),
    .product (mul_product)
  );

  // Control FSM, accumulator updates and registered response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      func_q      <= '0;
      sid_q       <= '0;
      resp_ready  <= 1'b0;
      resp_data   <= '0;
      resp_status <= STATUS_OK;
      busy        <= 1'b0;
      // NOTE: the accumulators are architectural state that must read 0 after
      // reset, so this memory is reset explicitly rather than left undefined.
      for (int i = 0; i < N_STATES; i++) acc[i] <= '0;
    end else begin
      // Response outputs are zero except in the single DONE cycle.
      resp_ready  <= 1'b0;
      resp_data   <= '0;
      resp_status <= STATUS_OK;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            func_q <= req_func;
            sid_q  <= req_state_id;
            if (mul_start) begin
              state <= ST_MUL;
              busy  <= 1'b1;
            end else begin
              state      <= ST_DONE;
              busy       <= 1'b1;
              resp_ready <= 1'b1;
              if (!legal_func) begin
                resp_status <= STATUS_ILL_FUNC;
              end else if (func_uses_state(req_func) && !legal_state) begin
                resp_status <= STATUS_ILL_STATE;
              end else begin
                case (req_func)
                  3'(FUNC_ADD):   resp_data <= req_data0 + req_data1;
                  3'(FUNC_RDACC): resp_data <= acc[req_state_id];
                  3'(FUNC_WRACC): begin
                    resp_data          <= acc[req_state_id];
                    acc[req_state_id]  <= req_data0;
                  end
                  3'(FUNC_CLRACC): acc[req_state_id] <= '0;
                  default: resp_data <= '0;
                endcase
              end
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state      <= ST_DONE;
            resp_ready <= 1'b1;
            if (func_q == 3'(FUNC_MAC)) begin
              acc[sid_q] <= mac_sum;
              resp_data  <= mac_sum;
            end else begin
              resp_data  <= mul_product;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cxu_mac.sv
// Self-checking bench for cxu_mac: directed cases, random requests against an
// arithmetic reference model, and reset during an in-flight MAC.
module tb_cxu_mac;

  localparam int NS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_func = '0;
  logic [1:0]  req_state_id = '0;
  logic [31:0] req_data0 = '0;
  logic [31:0] req_data1 = '0;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [3:0]  resp_status;
  logic        busy;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] acc_m [4];

  cxu_mac #(.N_STATES(NS)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_func     (req_func),
    .req_state_id (req_state_id),
    .req_data0    (req_data0),
    .req_data1    (req_data1),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_status  (resp_status),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference behaviour: expected result, status and latency; updates acc_m.
  task automatic model(input logic [2:0] f, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] d, output logic [3:0] st, output int lat);
    logic [31:0] p;
    d = 0; st = 0; lat = 1;
    p = a * b;
    if (f > 3'd5) st = 4'd1;
    else if (f >= 3'd2 && int'(s) >= NS) st = 4'd2;
    else begin
      case (f)
        3'd0: d = a + b;
        3'd1: begin d = p; lat = 33; end
        3'd2: begin acc_m[s] = acc_m[s] + p; d = acc_m[s]; lat = 33; end
        3'd3: d = acc_m[s];
        3'd4: begin d = acc_m[s]; acc_m[s] = a; end
        default: begin acc_m[s] = 0; d = 0; end
      endcase
    end
  endtask

  task automatic run_req(input string tag, input logic [2:0] f, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ed;
    logic [3:0]  est;
    int          elat;
    int          lat;
    bit          seen;
    model(f, s, a, b, ed, est, elat);
    @(negedge clk);
    req_valid = 1'b1; req_func = f; req_state_id = s; req_data0 = a; req_data1 = b;
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (resp_ready) seen = 1;
      // Scramble operands after accept; the unit must ignore them.
      req_data0 = $urandom; req_data1 = $urandom;
    end
    req_valid = 1'b0;
    if (!seen) begin
      check({tag, "/timeout"}, 32'(resp_ready), 32'd1);
      return;
    end
    check({tag, "/latency"}, 32'(lat), 32'(elat));
    check({tag, "/data"}, resp_data, ed);
    check({tag, "/status"}, 32'(resp_status), 32'(est));
    check({tag, "/busy"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    check({tag, "/pulse_end"}, {resp_ready, busy, resp_status, resp_data[25:0]}, 32'd0);
  endtask

  initial begin
    bit got_resp;
    for (int i = 0; i < 4; i++) acc_m[i] = 0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset/outputs", {resp_ready, busy, resp_status, resp_data[25:0]}, 32'd0);
    check("reset/data", resp_data, 32'd0);
    @(negedge clk) rst = 1'b1;

    for (int s = 0; s < 4; s++) run_req($sformatf("rdacc_init%0d", s), 3'd3, 2'(s), 0, 0);
    run_req("add_wrap", 3'd0, 0, 32'hFFFF_FFFF, 32'h0000_0002);
    run_req("mul_ff", 3'd1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_req("mul_shift", 3'd1, 0, 32'h0001_2345, 32'h0000_0010);
    run_req("wracc_s2", 3'd4, 2, 32'd5, 0);
    run_req("mac_s2", 3'd2, 2, 32'd3, 32'd4);
    run_req("rdacc_s2", 3'd3, 2, 0, 0);
    run_req("rdacc_s1", 3'd3, 1, 0, 0);
    run_req("clracc_s2", 3'd4 + 3'd1, 2, 0, 0);
    run_req("rdacc_s2_clr", 3'd3, 2, 0, 0);
    run_req("wracc_s0", 3'd4, 0, 32'hDEAD_BEEF, 0);
    run_req("ill_func7", 3'd7, 0, 32'h1234, 32'h5678);
    run_req("ill_func6", 3'd6, 0, 32'h1, 32'h1);
    run_req("ill_state_rd", 3'd3, 3, 0, 0);
    run_req("ill_state_mac", 3'd2, 3, 32'd9, 32'd9);
    run_req("ill_state_wr", 3'd4, 3, 32'd77, 0);
    for (int s = 0; s < NS; s++) run_req($sformatf("rdacc_after_ill%0d", s), 3'd3, 2'(s), 0, 0);

    // Random requests against the model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
      run_req($sformatf("rand%0d", i), 3'($urandom_range(7)), 2'($urandom_range(3)), a, b);
    end

    // Reset during a MAC: no response, all accumulators cleared.
    for (int s = 0; s < NS; s++) run_req($sformatf("prefill%0d", s), 3'd4, 2'(s), 32'h100 + 32'(s), 0);
    @(negedge clk);
    req_valid = 1'b1; req_func = 3'd2; req_state_id = 2'd1; req_data0 = 32'd7; req_data1 = 32'd9;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst/outputs", {resp_ready, busy, resp_status, resp_data[25:0]}, 32'd0);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 4; i++) acc_m[i] = 0;
    got_resp = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (resp_ready) got_resp = 1;
    end
    check("midrst/no_resp", 32'(got_resp), 32'd0);
    check("midrst/idle", 32'(busy), 32'd0);
    for (int s = 0; s < NS; s++) run_req($sformatf("midrst_rd%0d", s), 3'd3, 2'(s), 0, 0);
    run_req("midrst_add", 3'd0, 0, 32'h8000_0000, 32'h8000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
